// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types and constants used by the fetch stage.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } if_entry_t;

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// Single-entry instruction+PC buffer that parks a fetched word while the IF/ID slot is stalled.
module if_hold_buf
  import rv32i_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      i_load,
  input  logic      i_drain,
  input  logic      i_flush,
  input  if_entry_t i_entry,
  output logic      o_valid,
  output if_entry_t o_entry
);

  logic      r_valid;
  if_entry_t r_entry;

  // Flush wins over load, load wins over drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
      end else if (i_drain) begin
        r_valid <= 1'b0;
      end
      if (i_load && !i_flush) begin
        r_entry <= i_entry;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns the PC, issues one outstanding imem fetch at a time,
// and presents fetched words to decode through a registered valid/ready slot.
module if_stage
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  if_state_t       r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pend_pc;
  logic            r_kill;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_instr;
  logic [XLEN-1:0] r_if_pc;

  if_state_t       w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_pend_pc_nxt;
  logic            w_kill_nxt;
  logic            w_if_valid_nxt;
  logic [XLEN-1:0] w_if_instr_nxt;
  logic [XLEN-1:0] w_if_pc_nxt;
  logic            w_slot_free;
  logic            w_hold_load;
  logic            w_hold_drain;
  logic            w_hold_flush;
  logic            w_hold_valid;
  if_entry_t       w_hold_in;
  if_entry_t       w_hold_out;

  assign w_hold_in = '{instr: imem_rsp_data, pc: r_pend_pc};

  if_hold_buf u_hold_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_hold_load),
    .i_drain (w_hold_drain),
    .i_flush (w_hold_flush),
    .i_entry (w_hold_in),
    .o_valid (w_hold_valid),
    .o_entry (w_hold_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_pend_pc  <= '0;
      r_kill     <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
      r_if_pc    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
      r_kill     <= w_kill_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_if_pc    <= w_if_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_pc_nxt  = r_pend_pc;
    w_kill_nxt     = r_kill;
    w_if_valid_nxt = r_if_valid;
    w_if_instr_nxt = r_if_instr;
    w_if_pc_nxt    = r_if_pc;
    w_hold_load    = 1'b0;
    w_hold_drain   = 1'b0;
    w_hold_flush   = 1'b0;
    w_slot_free    = !r_if_valid || id_ready;

    // Decode consumed the slot; refilled below if a word is ready this cycle.
    if (r_if_valid && id_ready) begin
      w_if_valid_nxt = 1'b0;
      w_if_instr_nxt = NOP_INSTR;
    end

    case (r_state)
      FETCH: begin
        if (imem_req_ready) begin
          w_pend_pc_nxt = r_pc;
          w_state_nxt   = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (r_kill) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = FETCH;
          end else begin
            w_pc_nxt = pc_next(r_pend_pc);
            if (w_slot_free) begin
              w_if_valid_nxt = 1'b1;
              w_if_instr_nxt = imem_rsp_data;
              w_if_pc_nxt    = r_pend_pc;
              w_state_nxt    = FETCH;
            end else begin
              w_hold_load = 1'b1;
              w_state_nxt = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (id_ready) begin
          w_if_valid_nxt = w_hold_valid;
          w_if_instr_nxt = w_hold_valid ? w_hold_out.instr : NOP_INSTR;
          w_if_pc_nxt    = w_hold_out.pc;
          w_hold_drain   = 1'b1;
          w_state_nxt    = FETCH;
        end
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase

    // Redirect overrides everything; a fetch still outstanding must be killed on return.
    if (redirect_valid) begin
      w_pc_nxt       = pc_align(redirect_pc);
      w_if_valid_nxt = 1'b0;
      w_if_instr_nxt = NOP_INSTR;
      w_if_pc_nxt    = r_if_pc;
      w_hold_flush   = 1'b1;
      w_hold_load    = 1'b0;
      w_hold_drain   = 1'b0;
      if (((r_state == WAIT) && !imem_rsp_valid) ||
          ((r_state == FETCH) && imem_req_ready)) begin
        w_state_nxt = WAIT;
        w_kill_nxt  = 1'b1;
      end else begin
        w_state_nxt = FETCH;
        w_kill_nxt  = 1'b0;
      end
    end
  end

  assign imem_req_valid = (r_state == FETCH);
  assign imem_req_addr  = r_pc;
  assign if_valid       = r_if_valid;
  assign if_instr       = r_if_instr;
  assign if_pc          = r_if_pc;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by randomized traffic, all checked against
// a program-order fetch-stream model and a behavioural memory with configurable latency.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc;
  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          rsp_delay;
  int          n_consumed;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .id_ready       (id_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  // Memory contents: two known words at 0 and 4, a unique hash everywhere else.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    else if (a == 32'h4) return 32'h0020_0113;
    else return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  // One clock: stream/invariant checks before the edge, memory response after it.
  task automatic tick();
    logic        hs;
    logic [31:0] ha;
    logic        hold_slot;
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    logic        hold_req;
    hs = imem_req_valid && imem_req_ready;
    ha = imem_req_addr;
    if (!if_valid) check("nop_when_empty", if_instr, NOP);
    if (if_valid && id_ready) begin
      check("stream_pc", if_pc, exp_pc);
      check("stream_instr", if_instr, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_consumed++;
    end
    if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
    hold_slot = if_valid && !id_ready && !redirect_valid;
    s_pc      = if_pc;
    s_instr   = if_instr;
    hold_req  = imem_req_valid && !imem_req_ready && !redirect_valid;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (hs) begin
      pend      = 1'b1;
      pend_cnt  = rsp_delay;
      pend_addr = ha;
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend           = 1'b0;
      end
    end
    if (hold_slot) begin
      check_b("slot_stable_valid", if_valid, 1'b1);
      check("slot_stable_pc", if_pc, s_pc);
      check("slot_stable_instr", if_instr, s_instr);
    end
    if (hold_req) begin
      check_b("req_stable_valid", imem_req_valid, 1'b1);
      check("req_stable_addr", imem_req_addr, ha);
    end
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!if_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check_b(tag, if_valid, 1'b1);
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    pend           = 1'b0;
    exp_pc         = RST_PC;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n        = 1'b1;
    id_ready       = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    rsp_delay      = 1;
    pend           = 1'b0;
    pend_cnt       = 0;
    pend_addr      = 32'h0;
    n_consumed     = 0;
    exp_pc         = RST_PC;
    #1 reset_n = 1'b0;
    #2;
    check_b("rst_if_valid", if_valid, 1'b0);
    check("rst_if_instr", if_instr, NOP);
    check("rst_if_pc", if_pc, 32'h0);
    check_b("rst_req_valid", imem_req_valid, 1'b1);
    check("rst_req_addr", imem_req_addr, RST_PC);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Back-to-back fetch with 1-cycle memory and no stall.
    check("a_req_addr0", imem_req_addr, 32'h0);
    tick();
    check_b("a_c1_valid", if_valid, 1'b0);
    check_b("a_c1_req", imem_req_valid, 1'b0);
    tick();
    check_b("a_c2_valid", if_valid, 1'b1);
    check("a_c2_pc", if_pc, 32'h0);
    check("a_c2_instr", if_instr, 32'h0010_0093);
    check("a_req_addr4", imem_req_addr, 32'h4);
    tick();
    check_b("a_c3_valid", if_valid, 1'b0);
    tick();
    check_b("a_c4_valid", if_valid, 1'b1);
    check("a_c4_pc", if_pc, 32'h4);
    check("a_c4_instr", if_instr, 32'h0020_0113);
    do_reset();

    // Decode stall: second word parks in the hold buffer, no requests in HOLD.
    tick();
    tick();
    check("b_c2_pc", if_pc, 32'h0);
    id_ready = 1'b0;
    tick();
    check_b("b_c3_valid", if_valid, 1'b1);
    check("b_c3_pc", if_pc, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_b("b_hold_no_req", imem_req_valid, 1'b0);
      check("b_hold_pc", if_pc, 32'h0);
      tick();
    end
    id_ready = 1'b1;
    check("b_c7_pc", if_pc, 32'h0);
    check_b("b_c7_no_req", imem_req_valid, 1'b0);
    tick();
    check_b("b_c8_valid", if_valid, 1'b1);
    check("b_c8_pc", if_pc, 32'h4);
    check("b_c8_instr", if_instr, 32'h0020_0113);
    check("b_c8_req_addr", imem_req_addr, 32'h8);

    // Redirect while waiting on pc 8 with no response yet.
    rsp_delay = 2;
    tick();
    check_b("c_c9_valid", if_valid, 1'b0);
    check_b("c_c9_wait", imem_req_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    rsp_delay      = 1;
    check_b("c_c10_valid", if_valid, 1'b0);
    check_b("c_c10_wait", imem_req_valid, 1'b0);
    tick();
    check_b("c_c11_valid", if_valid, 1'b0);
    check_b("c_c11_req", imem_req_valid, 1'b1);
    check("c_c11_addr", imem_req_addr, 32'h0000_0100);
    tick();
    check_b("c_c12_valid", if_valid, 1'b0);
    tick();
    check_b("c_c13_valid", if_valid, 1'b1);
    check("c_c13_pc", if_pc, 32'h0000_0100);
    check("c_c13_addr", imem_req_addr, 32'h0000_0104);
    tick();

    // Redirect coinciding with a response, then with a request handshake.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    tick();
    check_b("d_c15_valid", if_valid, 1'b0);
    check("d_c15_addr", imem_req_addr, 32'h0000_0200);
    redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    check_b("d_c16_valid", if_valid, 1'b0);
    check_b("d_c16_wait", imem_req_valid, 1'b0);
    tick();
    check_b("d_c17_req", imem_req_valid, 1'b1);
    check("d_c17_addr", imem_req_addr, 32'h0000_0100);
    tick();
    wait_valid("d_valid_timeout", 10);
    check("d_pc", if_pc, 32'h0000_0100);

    // Memory not ready for 3 cycles.
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_b("e_req_valid", imem_req_valid, 1'b1);
      check("e_req_addr", imem_req_addr, 32'h0000_0104);
      tick();
    end
    imem_req_ready = 1'b1;
    check("e_release_addr", imem_req_addr, 32'h0000_0104);
    tick();
    wait_valid("e_valid_timeout", 10);
    check("e_pc", if_pc, 32'h0000_0104);

    // Unaligned redirect near the top of the address space; PC wraps to 0.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    wait_valid("f_first_timeout", 20);
    check("f_first_pc", if_pc, 32'hFFFF_FFFC);
    tick();
    wait_valid("f_second_timeout", 20);
    check("f_wrap_pc", if_pc, 32'h0);
    check("f_wrap_instr", if_instr, 32'h0010_0093);

    // Asynchronous reset while waiting with a full slot.
    tick();
    wait_valid("g_valid_timeout", 20);
    check("g_pre_pc", if_pc, 32'h4);
    id_ready  = 1'b0;
    rsp_delay = 3;
    tick();
    check_b("g_wait_valid", if_valid, 1'b1);
    check_b("g_wait_noreq", imem_req_valid, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_b("g_rst_valid", if_valid, 1'b0);
    check("g_rst_instr", if_instr, NOP);
    check("g_rst_pc", if_pc, 32'h0);
    check_b("g_rst_req", imem_req_valid, 1'b1);
    check("g_rst_addr", imem_req_addr, RST_PC);
    pend           = 1'b0;
    imem_rsp_valid = 1'b0;
    exp_pc         = RST_PC;
    id_ready       = 1'b1;
    rsp_delay      = 1;
    @(posedge clk);
    #1 reset_n = 1'b1;
    check_b("g_post_req", imem_req_valid, 1'b1);
    check("g_post_addr", imem_req_addr, RST_PC);
    wait_valid("g_post_timeout", 10);
    check("g_post_pc", if_pc, RST_PC);

    // Randomized traffic against the fetch-stream model.
    for (int c = 0; c < 2000; c++) begin
      id_ready       = ($urandom_range(0, 9) < 7);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      rsp_delay      = int'($urandom_range(1, 3));
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else redirect_pc = $urandom();
      tick();
    end
    redirect_valid = 1'b0;
    check_b("random_progress", n_consumed >= 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RV32I pipeline, directly upstream of `id_stage`. It owns the program counter and issues word fetches over a valid/ready instruction-memory port, holding at most one request in flight. Fetched words are presented to `id_stage` through a registered valid/ready IF/ID slot. Branch and jump redirects from later stages flush that slot and squash any in-flight fetch.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_ready` input 1: memory accepts request.
- `imem_req_addr` output 32: word-aligned fetch address.
- `imem_rsp_valid` input 1: response data valid; memory never back-pressures responses.
- `imem_rsp_data` input 32: fetched instruction word.
- `redirect_valid` input 1: branch taken or jump resolved downstream.
- `redirect_pc` input 32: redirect target.
- `if_valid` output 1: IF/ID slot holds an instruction.
- `id_ready` input 1: `id_stage` consumes the slot this cycle.
- `if_instr` output 32: instruction to `id_stage`.
- `if_pc` output 32: PC of `if_instr`.

## Operation
- State machine, states `FETCH`, `WAIT`, `HOLD`:
  - FETCH: `imem_req_valid`=1 and `imem_req_addr`=`pc`. On `imem_req_ready`, latch `pc` into `pend_pc` and go to WAIT.
  - WAIT: wait for `imem_rsp_valid`.
    - If `kill`=1: discard the response, clear `kill`, go to FETCH.
    - Else, if the slot is free (`!if_valid || id_ready`): load the slot, set `pc`=`pend_pc`+4, go to FETCH.
    - Else: store the word in the hold buffer, set `pc`=`pend_pc`+4, go to HOLD.
  - HOLD: when `id_ready`=1, move the buffered word and its PC into the slot and go to FETCH. No request is issued in HOLD.
- Redirect has highest priority, in every state:
  - `pc` = {`redirect_pc`[31:2], 2'b00}; the low bits are silently cleared.
  - `if_valid` = 0 and the hold buffer is invalidated.
  - If the state is WAIT and no response arrives that cycle, set `kill`=1 and stay in WAIT. Otherwise go to FETCH.
  - A request handshaking in the same cycle as a redirect is still in flight. Go to WAIT with `kill`=1.
  - A response arriving in the same cycle as a redirect is discarded.
- `if_instr` = 32'h0000_0013 (addi x0,x0,0) whenever `if_valid`=0. `if_pc` holds its last value.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Mid-operation `reset_n` low immediately drops the fetch; a late memory response after reset release is not expected.

## Timing
- Reset values:
  - `pc`=`RESET_PC`; state FETCH; `kill`=0.
  - `if_valid`=0, `if_instr`=32'h0000_0013, `if_pc`=0, hold buffer empty.
  - `imem_req_valid`=1 from the first cycle after `reset_n` rises, and during reset as a combinational function of state.
- `imem_req_valid` and `imem_req_addr` are combinational from state and `pc`; they stay stable until `imem_req_ready`.
- With a 1-cycle memory, the request handshakes at cycle N, the response arrives at N+1, and `if_valid`=1 at N+2.
- Throughput with zero-wait memory and no stall: one instruction per 2 cycles.
- Once `if_valid` is set, the slot is stable until `id_ready`, then it is overwritten or cleared the next cycle.
- Redirect at cycle N: `if_valid`=0 at N+1, and a request to the new PC is issued at N+1 unless WAIT plus `kill` applies.

## Structure
- `rv32i_pkg` holds:
  - `NOP_INSTR` = 32'h0000_0013.
  - `if_state_t` enum {FETCH, WAIT, HOLD}.
  - a shared `XLEN` = 32.
- One sub-module, `if_hold_buf`: a single-entry instr+pc buffer with load, drain and flush inputs and a valid output. Everything else stays in `if_stage`.

## Test plan
- Reset release, memory always ready with 1-cycle responses, words 32'h00100093 and 32'h00200113, `id_ready`=1:
  - `imem_req_addr` reads 0, then 4.
  - `if_pc`/`if_instr` read 0/00100093, then 4/00200113.
  - `if_valid` toggles every 2 cycles.
- Hold `id_ready`=0 for 5 cycles after the first instruction:
  - the slot stays at pc 0.
  - the second word (pc 4) goes to the HOLD buffer and no request is issued.
  - after `id_ready` goes high, pc 4 appears on the cycle after pc 0 is consumed.
- `redirect_valid`=1 with `redirect_pc`=32'h0000_0100 while in WAIT for pc 8:
  - the response for pc 8 is discarded and `if_valid` stays 0.
  - the next request address is 0x100.
  - `if_pc`=0x100 is the next valid output.
- Redirect in the same cycle as a response, and redirect in the same cycle as a request handshake:
  - neither stale word ever reaches `if_valid`=1.
  - `redirect_pc`=32'h0000_0103 fetches 0x100.
- `imem_req_ready` held low for 3 cycles: `imem_req_valid` and `imem_req_addr` stay stable and no PC increment occurs.
- Assert `reset_n`=0 asynchronously mid-WAIT with `if_valid`=1:
  - `if_valid`=0, `if_instr`=32'h00000013, `pc`=`RESET_PC` immediately.
  - the first request after release targets `RESET_PC`.
